calc_sequencer: RTL

Key-driven controller that sequences the shared Calculate datapath (2-bit op select, two 32-bit BCD operands; result/mod/negative/overflow/error back). Collects operand A, operator and operand B from debounced key pulses, presents them to the datapath, waits a fixed settle time, and latches the outcome for the display. Sits between the keypad decoder and the 7-segment display driver.

---
 rtl/calc_sequencer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer for the shared Calculate datapath: operand/operator entry, settle wait, result capture.
// Optional remainder view in SHOW is enabled by defining CALC_SEQ_MOD_EN.
module calc_sequencer #(
  parameter int DIGITS       = 4,
  parameter int CALC_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        digit_vld,
  input  logic [3:0]  digit,
  input  logic        op_vld,
  input  logic [1:0]  op,
  input  logic        eq_vld,
  input  logic        clr_vld,
  input  logic        mod_vld,
  output logic [1:0]  switches,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  input  logic [31:0] result,
  input  logic [31:0] mod,
  input  logic        negative,
  input  logic        overflow,
  input  logic        error,
  output logic [31:0] disp_value,
  output logic        disp_neg,
  output logic        disp_ovf,
  output logic        disp_err,
  output logic        busy,
  output logic        res_vld
);

  localparam int            CW        = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(DIGITS);
  localparam logic [3:0]    WAIT_LOAD = 4'(CALC_LATENCY - 1);

  typedef enum logic [1:0] {ENTER_A, ENTER_B, WAIT, SHOW} state_t;

  state_t        state, state_nxt;
  logic [31:0]   a_nxt, b_nxt;
  logic [1:0]    sw_nxt;
  logic [CW-1:0] cnt_a, cnt_a_nxt, cnt_b, cnt_b_nxt;
  logic [3:0]    wcnt, wcnt_nxt;
  logic          capture;
  logic [31:0]   cap_result;
  logic          cap_neg, cap_ovf, cap_err;
  logic          key_eq, key_op, key_dig, chain_ok;

`ifdef CALC_SEQ_MOD_EN
  logic [31:0] cap_mod;
  logic        view, view_nxt;
  logic        key_mod;
  assign key_mod = mod_vld && !clr_vld && !eq_vld && !op_vld && !digit_vld;
`else
  logic unused_mod;
  assign unused_mod = ^{mod, mod_vld};
`endif

  // One key wins per cycle: clr > eq > op > digit; invalid digit codes never count as a key press.
  assign key_eq   = eq_vld && !clr_vld;
  assign key_op   = op_vld && !clr_vld && !eq_vld;
  assign key_dig  = digit_vld && !clr_vld && !eq_vld && !op_vld && (digit <= 4'd9);
  assign chain_ok = !cap_neg && !cap_ovf && !cap_err;
  assign busy     = (state == WAIT);

  always_comb begin
    state_nxt = state;
    a_nxt     = operand1;
    b_nxt     = operand2;
    sw_nxt    = switches;
    cnt_a_nxt = cnt_a;
    cnt_b_nxt = cnt_b;
    wcnt_nxt  = wcnt;
    capture   = 1'b0;
`ifdef CALC_SEQ_MOD_EN
    view_nxt  = view;
`endif
    if (clr_vld) begin
      state_nxt = ENTER_A;
      a_nxt     = '0;
      b_nxt     = '0;
      sw_nxt    = '0;
      cnt_a_nxt = '0;
      cnt_b_nxt = '0;
      wcnt_nxt  = '0;
    end else begin
      case (state)
        ENTER_A: begin
          if (key_op) begin
            sw_nxt    = op;
            b_nxt     = '0;
            cnt_b_nxt = '0;
            state_nxt = ENTER_B;
          end else if (key_dig && cnt_a != MAX_CNT) begin
            a_nxt     = {operand1[27:0], digit};
            cnt_a_nxt = cnt_a + CW'(1);
          end
        end
        ENTER_B: begin
          if (key_eq) begin
            wcnt_nxt  = WAIT_LOAD;
            state_nxt = WAIT;
          end else if (key_op) begin
            if (cnt_b == '0) sw_nxt = op;
          end else if (key_dig && cnt_b != MAX_CNT) begin
            b_nxt     = {operand2[27:0], digit};
            cnt_b_nxt = cnt_b + CW'(1);
          end
        end
        WAIT: begin
          if (wcnt == 4'd0) begin
            capture   = 1'b1;
            state_nxt = SHOW;
          end else begin
            wcnt_nxt = wcnt - 4'd1;
          end
        end
        SHOW: begin
          if (key_eq) begin
            wcnt_nxt  = WAIT_LOAD;
            state_nxt = WAIT;
          end else if (key_op) begin
            // Chaining only continues from a clean result.
            if (chain_ok) begin
              a_nxt     = cap_result;
              sw_nxt    = op;
              b_nxt     = '0;
              cnt_b_nxt = '0;
              state_nxt = ENTER_B;
            end
          end else if (key_dig) begin
            a_nxt     = {28'd0, digit};
            cnt_a_nxt = CW'(1);
            state_nxt = ENTER_A;
          end
`ifdef CALC_SEQ_MOD_EN
          else if (key_mod && switches == 2'd3 && !cap_err) begin
            view_nxt = !view;
          end
`endif
        end
        default: state_nxt = ENTER_A;
      endcase
    end
`ifdef CALC_SEQ_MOD_EN
    if (state_nxt != SHOW) view_nxt = 1'b0;
`endif
  end

  always_comb begin
    disp_value = '0;
    disp_neg   = 1'b0;
    disp_ovf   = 1'b0;
    disp_err   = 1'b0;
    case (state)
      ENTER_A:       disp_value = operand1;
      ENTER_B, WAIT: disp_value = operand2;
      SHOW: begin
        disp_neg = cap_neg;
        disp_ovf = cap_ovf;
        disp_err = cap_err;
        if (!cap_err) begin
`ifdef CALC_SEQ_MOD_EN
          disp_value = view ? cap_mod : cap_result;
`else
          disp_value = cap_result;
`endif
        end
      end
      default: disp_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ENTER_A;
      operand1   <= '0;
      operand2   <= '0;
      switches   <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      wcnt       <= '0;
      res_vld    <= 1'b0;
      cap_result <= '0;
      cap_neg    <= 1'b0;
      cap_ovf    <= 1'b0;
      cap_err    <= 1'b0;
`ifdef CALC_SEQ_MOD_EN
      cap_mod    <= '0;
      view       <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      operand1 <= a_nxt;
      operand2 <= b_nxt;
      switches <= sw_nxt;
      cnt_a    <= cnt_a_nxt;
      cnt_b    <= cnt_b_nxt;
      wcnt     <= wcnt_nxt;
      res_vld  <= capture;
`ifdef CALC_SEQ_MOD_EN
      view     <= view_nxt;
`endif
      if (clr_vld) begin
        cap_result <= '0;
        cap_neg    <= 1'b0;
        cap_ovf    <= 1'b0;
        cap_err    <= 1'b0;
`ifdef CALC_SEQ_MOD_EN
        cap_mod    <= '0;
`endif
      end else if (capture) begin
        cap_result <= result;
        cap_neg    <= negative;
        cap_ovf    <= overflow;
        cap_err    <= error;
`ifdef CALC_SEQ_MOD_EN
        cap_mod    <= mod;
`endif
      end
    end
  end

endmodule
